// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory bus bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } dmem_state_t;

    localparam int unsigned DMEM_TIMEOUT_DEF = 16;

    function automatic int unsigned dmem_cnt_width(input int unsigned timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Bus wait counter: cleared when a transaction starts, flags expiry at TIMEOUT-1.
module bus_timer
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = dmem_cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Hold at the expiry value; the bridge leaves REQ/WAIT on that cycle anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges core execute-stage loads/stores onto a valid/ready bus with a
// separate read-data return, stalling the core until the access completes.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         memRead_ex,
    input  logic         memWrite_ex,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] dt_in,
    output logic [N-1:0] dt_out,
    output logic         stall,
    output logic         bus_valid,
    input  logic         bus_ready,
    output logic         bus_we,
    output logic [N-1:0] bus_addr,
    output logic [N-1:0] bus_wdata,
    input  logic         bus_rvalid,
    input  logic [N-1:0] bus_rdata,
    output logic         err
);

    dmem_state_t  state_q, state_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] dt_q, dt_d;
    logic         we_q, we_d;
    logic         err_q, err_d;
    logic         req_in;
    logic         tmr_clear;
    logic         tmr_en;
    logic         expired;

    assign req_in = memRead_ex | memWrite_ex;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        dt_d      = dt_q;
        err_d     = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        stall     = 1'b0;
        bus_valid = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_in) begin
                    stall     = 1'b1;
                    addr_d    = alu_result;
                    wdata_d   = dt_in;
                    we_d      = memWrite_ex;
                    tmr_clear = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                tmr_en    = 1'b1;
                // Completion is tested before expiry so it wins a same-cycle tie.
                if (bus_ready && (we_q || bus_rvalid)) begin
                    if (!we_q) begin
                        dt_d = bus_rdata;
                    end
                    state_d = StDone;
                end else if (expired) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        dt_d = '0;
                    end
                    state_d = StDone;
                end else if (bus_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                stall  = 1'b1;
                tmr_en = 1'b1;
                if (bus_rvalid) begin
                    dt_d    = bus_rdata;
                    state_d = StDone;
                end else if (expired) begin
                    err_d   = 1'b1;
                    dt_d    = '0;
                    state_d = StDone;
                end
            end
            // A request seen here belongs to the access just finished.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            dt_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            dt_q    <= dt_d;
            err_q   <= err_d;
        end
    end

    assign dt_out    = dt_q;
    assign err       = err_q;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stores, loads, timeout, priority, reset abort.
module tb_dmem_bridge;
    import dmem_pkg::*;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic         memRead_ex;
    logic         memWrite_ex;
    logic [N-1:0] alu_result;
    logic [N-1:0] dt_in;
    logic [N-1:0] dt_out;
    logic         stall;
    logic         bus_valid;
    logic         bus_ready;
    logic         bus_we;
    logic [N-1:0] bus_addr;
    logic [N-1:0] bus_wdata;
    logic         bus_rvalid;
    logic [N-1:0] bus_rdata;
    logic         err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_valid  = 0;
    int unsigned n_acc    = 0;
    int unsigned n_err    = 0;

    dmem_bridge #(
        .N       (N),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .memRead_ex  (memRead_ex),
        .memWrite_ex (memWrite_ex),
        .alu_result  (alu_result),
        .dt_in       (dt_in),
        .dt_out      (dt_out),
        .stall       (stall),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Bus activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_valid) n_valid <= n_valid + 1;
        if (bus_valid && bus_ready) n_acc <= n_acc + 1;
        if (err) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned v0;
        int unsigned a0;
        int unsigned e0;

        rstn = 1'b0; memRead_ex = 1'b0; memWrite_ex = 1'b0;
        alu_result = '0; dt_in = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) next();
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_valid", bus_valid, 0);
        check("rst_err", err, 0);
        check("rst_dt", dt_out, 0);
        check("rst_state", dut.state_q, StIdle);
        next();
        rstn = 1'b1;

        // Store, ready on the first REQ cycle.
        memWrite_ex = 1'b1; alu_result = 32'h0000_0010; dt_in = 32'hDEAD_BEEF; bus_ready = 1'b1;
        v0 = n_valid;
        @(negedge clk);
        check("wr_idle_stall", stall, 1);
        check("wr_idle_valid", bus_valid, 0);
        next();
        @(negedge clk);
        check("wr_req_valid", bus_valid, 1);
        check("wr_req_we", bus_we, 1);
        check("wr_req_addr", bus_addr, 32'h0000_0010);
        check("wr_req_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("wr_req_stall", stall, 1);
        next();
        @(negedge clk);
        check("wr_done_stall", stall, 0);
        check("wr_done_err", err, 0);
        check("wr_done_valid", bus_valid, 0);
        next();
        memWrite_ex = 1'b0; bus_ready = 1'b0;
        check("wr_nvalid", n_valid - v0, 1);

        // Load: ready in REQ, rvalid three cycles later.
        memRead_ex = 1'b1; alu_result = 32'h0000_0020; bus_ready = 1'b1;
        @(negedge clk);
        check("ld_idle_stall", stall, 1);
        next();
        @(negedge clk);
        check("ld_req_valid", bus_valid, 1);
        check("ld_req_we", bus_we, 0);
        check("ld_req_addr", bus_addr, 32'h0000_0020);
        next();
        bus_ready = 1'b0;
        @(negedge clk);
        check("ld_wait_valid", bus_valid, 0);
        check("ld_wait_stall", stall, 1);
        next();
        next();
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("ld_wait_dt_old", dt_out, 0);
        next();
        bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("ld_done_dt", dt_out, 32'h1234_5678);
        check("ld_done_stall", stall, 0);
        check("ld_done_err", err, 0);
        next();
        memRead_ex = 1'b0;

        // Read and write together: the write wins, dt_out untouched.
        memRead_ex = 1'b1; memWrite_ex = 1'b1; alu_result = 32'h0000_0044;
        dt_in = 32'hCAFE_F00D; bus_ready = 1'b1;
        v0 = n_valid;
        next();
        @(negedge clk);
        check("both_we", bus_we, 1);
        check("both_wdata", bus_wdata, 32'hCAFE_F00D);
        next();
        @(negedge clk);
        check("both_dt_keep", dt_out, 32'h1234_5678);
        check("both_done_stall", stall, 0);
        next();
        memRead_ex = 1'b0; memWrite_ex = 1'b0; bus_ready = 1'b0;
        check("both_nvalid", n_valid - v0, 1);

        // Load that never sees ready: 16 REQ cycles then a timed-out DONE.
        memRead_ex = 1'b1; alu_result = 32'h0000_0030;
        v0 = n_valid; e0 = n_err;
        next();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0 || i == 15) begin
                check("to_req_valid", bus_valid, 1);
                check("to_req_stall", stall, 1);
            end
            next();
        end
        @(negedge clk);
        check("to_done_err", err, 1);
        check("to_done_dt", dt_out, 0);
        check("to_done_stall", stall, 0);
        check("to_done_valid", bus_valid, 0);
        next();
        memRead_ex = 1'b0;
        @(negedge clk);
        check("to_err_pulse", err, 0);
        next();
        check("to_nvalid", n_valid - v0, 16);
        check("to_nerr", n_err - e0, 1);

        // Back-to-back loads; the first request is still present during DONE.
        memRead_ex = 1'b1; alu_result = 32'h0000_0050;
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        v0 = n_valid; a0 = n_acc;
        @(negedge clk);
        check("b2b_idle_stall", stall, 1);
        next();
        next();
        @(negedge clk);
        check("b2b_done1_dt", dt_out, 32'h1111_1111);
        check("b2b_done1_stall", stall, 0);
        next();
        alu_result = 32'h0000_0054; bus_rdata = 32'h2222_2222;
        @(negedge clk);
        check("b2b_idle2_stall", stall, 1);
        next();
        @(negedge clk);
        check("b2b_req2_addr", bus_addr, 32'h0000_0054);
        next();
        @(negedge clk);
        check("b2b_done2_dt", dt_out, 32'h2222_2222);
        next();
        memRead_ex = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        next();
        check("b2b_nvalid", n_valid - v0, 2);
        check("b2b_nacc", n_acc - a0, 2);

        // Reset while in WAIT; a late rvalid must be ignored.
        memRead_ex = 1'b1; alu_result = 32'h0000_0060; bus_ready = 1'b1;
        e0 = n_err;
        next();
        next();
        bus_ready = 1'b0;
        rstn = 1'b0; memRead_ex = 1'b0;
        @(negedge clk);
        check("rw_wait_state", dut.state_q, StWait);
        next();
        rstn = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
        @(negedge clk);
        check("rw_state", dut.state_q, StIdle);
        check("rw_valid", bus_valid, 0);
        check("rw_stall", stall, 0);
        check("rw_dt", dt_out, 0);
        next();
        bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("rw_dt_late", dt_out, 0);
        check("rw_state_late", dut.state_q, StIdle);
        next();
        check("rw_nerr", n_err - e0, 0);

        // Completion on the expiry cycle: completion wins, no err.
        memRead_ex = 1'b1; alu_result = 32'h0000_0070;
        repeat (16) next();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hABCD_0123;
        @(negedge clk);
        check("tie_req_valid", bus_valid, 1);
        next();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        check("tie_err", err, 0);
        check("tie_dt", dt_out, 32'hABCD_0123);
        check("tie_stall", stall, 0);
        next();
        memRead_ex = 1'b0;
        next();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
